rtc_bus_driver: RTL and testbench

- Physical bus stage between the RTC controller FSM and the external RTC chip.
- Converts one-cycle read/write requests into multiplexed address/data bus cycles: address phase, then data phase.
- Drives AD, CS, RD and WR, and the bidirectional 8-bit bus. Captures read data.
- Also conditions the RTC IRQ line.

---
 rtl/rtc_bus_driver.sv | 195 +++++++++++++++++++
 tb/tb_rtc_bus_driver.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rtc_bus_driver.sv
// rtc_bus_driver: physical bus stage to an external RTC chip.
// Each request becomes an address phase and a data phase on the shared
// 8-bit bus. The phases are separated by an idle gap.
// All strobes and the bus output enable come straight from flops, so they
// lag the internal state by one cycle.
// Optional build macro IRQ_LATCH_EN adds the synchronised IRQ latch.
// Without it, irq_pending is tied low.
//
// Handshake: a request is taken when start=1 at a clock edge while the FSM
// is idle. busy is high from the next cycle until the cycle after the
// one-cycle done pulse. A start seen while a request is in flight is dropped.
module rtc_bus_driver #(
  parameter int T_SETUP = 1,
  parameter int T_PULSE = 3,
  parameter int T_HOLD  = 1,
  parameter int T_GAP   = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       rw,
  input  logic [7:0] addr,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       busy,
  output logic       done,
  inout  wire  [7:0] bus,
  output logic       AD,
  output logic       CS,
  output logic       RD,
  output logic       WR,
  input  logic       IRQ,
  input  logic       irq_ack,
  output logic       irq_pending,
  output logic [3:0] dbg_state
);

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_A_SETUP = 4'd1;
  localparam logic [3:0] S_A_PULSE = 4'd2;
  localparam logic [3:0] S_A_HOLD  = 4'd3;
  localparam logic [3:0] S_GAP     = 4'd4;
  localparam logic [3:0] S_D_SETUP = 4'd5;
  localparam logic [3:0] S_D_PULSE = 4'd6;
  localparam logic [3:0] S_D_HOLD  = 4'd7;
  localparam logic [3:0] S_FINISH  = 4'd8;

  // Counter reload values: a phase of N cycles counts N-1 down to 0.
  localparam logic [7:0] LD_SETUP = 8'(T_SETUP - 1);
  localparam logic [7:0] LD_PULSE = 8'(T_PULSE - 1);
  localparam logic [7:0] LD_HOLD  = 8'(T_HOLD - 1);
  localparam logic [7:0] LD_GAP   = 8'(T_GAP - 1);

  logic [3:0] state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       rw_q, rw_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d;

  logic       cs_q, cs_d, ad_q, ad_d, rd_q, rd_d, wr_q, wr_d;
  logic       oe_q, oe_d, busy_q, busy_d, done_q, done_d;
  logic [7:0] bus_out_q, bus_out_d, rdata_q, rdata_d;
  logic       in_a, in_d;

  // Next state, phase counter and request latch
  always_comb begin
    state_d = state_q;
    cnt_d   = (cnt_q != 8'd0) ? cnt_q - 8'd1 : cnt_q;
    rw_d    = rw_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      S_IDLE: if (start) begin
        rw_d    = rw;
        addr_d  = addr;
        wdata_d = wdata;
        state_d = S_A_SETUP;
        cnt_d   = LD_SETUP;
      end
      S_A_SETUP: if (cnt_q == 8'd0) begin state_d = S_A_PULSE; cnt_d = LD_PULSE; end
      S_A_PULSE: if (cnt_q == 8'd0) begin state_d = S_A_HOLD;  cnt_d = LD_HOLD;  end
      S_A_HOLD:  if (cnt_q == 8'd0) begin state_d = S_GAP;     cnt_d = LD_GAP;   end
      S_GAP:     if (cnt_q == 8'd0) begin state_d = S_D_SETUP; cnt_d = LD_SETUP; end
      S_D_SETUP: if (cnt_q == 8'd0) begin state_d = S_D_PULSE; cnt_d = LD_PULSE; end
      S_D_PULSE: if (cnt_q == 8'd0) begin state_d = S_D_HOLD;  cnt_d = LD_HOLD;  end
      S_D_HOLD:  if (cnt_q == 8'd0) begin state_d = S_FINISH;  cnt_d = 8'd0;     end
      S_FINISH:  state_d = S_IDLE;
      default: begin
        state_d = S_IDLE;
        cnt_d   = 8'd0;
      end
    endcase
  end

  // Output decode from the current state; registered below for clean strobes
  always_comb begin
    in_a      = (state_q == S_A_SETUP) || (state_q == S_A_PULSE) || (state_q == S_A_HOLD);
    in_d      = (state_q == S_D_SETUP) || (state_q == S_D_PULSE) || (state_q == S_D_HOLD);
    cs_d      = ~(in_a | in_d);
    ad_d      = ~in_a;
    wr_d      = ~((state_q == S_A_PULSE) || ((state_q == S_D_PULSE) && !rw_q));
    rd_d      = ~((state_q == S_D_PULSE) && rw_q);
    // Reads never enable the driver in the data phase, so it is off while RD is low.
    oe_d      = in_a | (in_d & ~rw_q);
    bus_out_d = in_a ? addr_q : wdata_q;
    busy_d    = (state_q != S_IDLE);
    done_d    = (state_q == S_FINISH);
    // Capture in the last cycle RD is low, i.e. just before it is released.
    rdata_d   = (rw_q && !rd_q && rd_d) ? bus : rdata_q;
  end

  // FSM and request registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
      rw_q    <= 1'b0;
      addr_q  <= 8'd0;
      wdata_q <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rw_q    <= rw_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  // Registered bus-side outputs and read data
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cs_q      <= 1'b1;
      ad_q      <= 1'b1;
      rd_q      <= 1'b1;
      wr_q      <= 1'b1;
      oe_q      <= 1'b0;
      bus_out_q <= 8'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rdata_q   <= 8'd0;
    end else begin
      cs_q      <= cs_d;
      ad_q      <= ad_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      oe_q      <= oe_d;
      bus_out_q <= bus_out_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      rdata_q   <= rdata_d;
    end
  end

  assign bus       = oe_q ? bus_out_q : 8'hzz;
  assign CS        = cs_q;
  assign AD        = ad_q;
  assign RD        = rd_q;
  assign WR        = wr_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign rdata     = rdata_q;
  assign dbg_state = state_q;

`ifdef IRQ_LATCH_EN
  logic sync1_q, sync2_q, prev_q, pend_q, pend_d;

  // Set on a synchronised falling edge; a new edge wins over a same-cycle ack.
  always_comb begin
    pend_d = pend_q;
    if (prev_q && !sync2_q) pend_d = 1'b1;
    else if (irq_ack)       pend_d = 1'b0;
  end

  // IRQ synchroniser, edge history and pending flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
      pend_q  <= 1'b0;
    end else begin
      sync1_q <= IRQ;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      pend_q  <= pend_d;
    end
  end

  assign irq_pending = pend_q;
`else
  wire unused_irq = &{1'b0, IRQ, irq_ack};
  assign irq_pending = 1'b0;
`endif

endmodule

// File: tb/tb_rtc_bus_driver.sv
// tb_rtc_bus_driver: drives rtc_bus_driver against a small RTC chip model.
// The chip latches the address on the WR pulse of the address phase, stores
// data on the WR pulse of the data phase, and drives the bus while RD is low.
// Expected waveforms are derived from the timing parameters by arithmetic.
// Expected read data comes from a reference copy of the register file.
// The bus carries a pull-up, so an undriven bus reads 8'hFF.
// Stimulus therefore never puts 8'hFF on the bus.
module tb_rtc_bus_driver;
  localparam int T_SETUP = 1;
  localparam int T_PULSE = 3;
  localparam int T_HOLD  = 1;
  localparam int T_GAP   = 2;
  localparam int LA      = T_SETUP + T_PULSE + T_HOLD;
  localparam int DS      = LA + T_GAP + 1;
  localparam int DONE_T  = 2 * LA + T_GAP + 1;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       rw = 1'b0;
  logic [7:0] addr = 8'h00;
  logic [7:0] wdata = 8'h00;
  logic       IRQ = 1'b1;
  logic       irq_ack = 1'b0;
  wire  [7:0] rdata;
  wire        busy, done, AD, CS, RD, WR, irq_pending;
  wire  [3:0] dbg_state;
  tri1  [7:0] bus;

  int total = 0;
  int bad   = 0;
  logic [7:0] ref_mem [256];
  logic [7:0] exp_q [$];
  logic [7:0] last_rd = 8'h00;

  rtc_bus_driver #(.T_SETUP(T_SETUP), .T_PULSE(T_PULSE), .T_HOLD(T_HOLD), .T_GAP(T_GAP)) dut (
    .clk(clk), .reset(reset), .start(start), .rw(rw), .addr(addr), .wdata(wdata),
    .rdata(rdata), .busy(busy), .done(done), .bus(bus), .AD(AD), .CS(CS), .RD(RD),
    .WR(WR), .IRQ(IRQ), .irq_ack(irq_ack), .irq_pending(irq_pending), .dbg_state(dbg_state)
  );

  // clock / timeout
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // RTC chip model
  logic [7:0] chip_mem [256];
  logic [7:0] chip_addr = 8'h00;
  wire        chip_drive = (RD == 1'b0) && (AD == 1'b1);
  wire  [7:0] chip_data  = chip_mem[chip_addr];
  assign bus = chip_drive ? chip_data : 8'hzz;

  initial begin
    for (int i = 0; i < 256; i++) chip_mem[i] = 8'(i) + 8'h23;
    forever begin
      @(posedge WR);
      if (AD == 1'b0) chip_addr = bus;
      else chip_mem[chip_addr] = bus;
    end
  end

  // One full request from its start cycle through the done cycle.
  // On return the bench sits in the done cycle, so a caller may start again.
  task automatic run_txn(input logic t_rw, input logic [7:0] t_addr, input logic [7:0] t_wdata,
                         input bit glitch, output int n_done);
    logic [5:0] exp_ctl, got_ctl;
    logic [7:0] exp_bus, rd_val;
    bit in_a, a_pulse, in_d, d_pulse;
    rd_val = ref_mem[t_addr];
    if (t_rw) exp_q.push_back(rd_val);
    else ref_mem[t_addr] = t_wdata;
    start = 1'b1; rw = t_rw; addr = t_addr; wdata = t_wdata;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    n_done = 0;
    for (int t = 0; t <= DONE_T; t++) begin
      if (t > 0) @(negedge clk);
      if (glitch && t == 4) begin
        start = 1'b1; rw = ~t_rw; addr = ~t_addr; wdata = 8'($urandom_range(0, 254));
      end else if (glitch && t == 5) begin
        start = 1'b0;
      end
      in_a    = (t >= 1) && (t <= LA);
      a_pulse = (t >= 1 + T_SETUP) && (t <= T_SETUP + T_PULSE);
      in_d    = (t >= DS) && (t < DS + LA);
      d_pulse = (t >= DS + T_SETUP) && (t < DS + T_SETUP + T_PULSE);
      // {AD, CS, RD, WR, busy, done}
      exp_ctl = {!in_a, !(in_a || in_d), !(d_pulse && t_rw), !(a_pulse || (d_pulse && !t_rw)),
                 (t >= 1) && (t <= DONE_T), t == DONE_T};
      got_ctl = {AD, CS, RD, WR, busy, done};
      exp_bus = in_a ? t_addr : (in_d && !t_rw) ? t_wdata : (d_pulse && t_rw) ? rd_val : 8'hFF;
      total++;
      if (got_ctl !== exp_ctl) begin
        bad++;
        $display("FAIL txn_ctl rw=%0d addr=%h t=%0d {AD,CS,RD,WR,busy,done} got=%b exp=%b",
                 t_rw, t_addr, t, got_ctl, exp_ctl);
      end
      total++;
      if (bus !== exp_bus) begin
        bad++;
        $display("FAIL txn_bus rw=%0d addr=%h t=%0d got=%h exp=%h", t_rw, t_addr, t, bus, exp_bus);
      end
      if (done === 1'b1) n_done++;
    end
    if (t_rw) last_rd = exp_q.pop_front();
    total++;
    if (rdata !== last_rd) begin
      bad++;
      $display("FAIL txn_rdata rw=%0d addr=%h got=%h exp=%h", t_rw, t_addr, rdata, last_rd);
    end
  endtask

  // Idle cycles: bus released, strobes high, nothing in flight.
  task automatic idle_cycles(input int n, output int n_done);
    n_done = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (done === 1'b1) n_done++;
      total++;
      if ({AD, CS, RD, WR, busy, done} !== 6'b111100 || bus !== 8'hFF) begin
        bad++;
        $display("FAIL idle {AD,CS,RD,WR,busy,done}=%b bus=%h exp 111100/ff",
                 {AD, CS, RD, WR, busy, done}, bus);
      end
    end
  endtask

  task automatic test_reset();
    #1 reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      start = (i % 2 == 0);
      #1;
      total++;
      if ({AD, CS, RD, WR, busy, done} !== 6'b111100 || bus !== 8'hFF || rdata !== 8'h00) begin
        bad++;
        $display("FAIL reset_hold ctl=%b bus=%h rdata=%h exp 111100/ff/00",
                 {AD, CS, RD, WR, busy, done}, bus, rdata);
      end
    end
    @(negedge clk);
    start = 1'b0;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if ({AD, CS, RD, WR, busy, done} !== 6'b111100 || bus !== 8'hFF || rdata !== 8'h00) begin
        bad++;
        $display("FAIL reset_release ctl=%b bus=%h rdata=%h exp 111100/ff/00",
                 {AD, CS, RD, WR, busy, done}, bus, rdata);
      end
    end
  endtask

  task automatic test_abort();
    int nd;
    nd = 0;
    start = 1'b1; rw = 1'b1; addr = 8'h2A; wdata = 8'h00;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int t = 1; t <= DS + T_SETUP + 1; t++) @(negedge clk);
    total++;
    if (RD !== 1'b0) begin
      bad++;
      $display("FAIL abort_in_pulse RD got=%b exp=0", RD);
    end
    #2 reset = 1'b0;
    #1;
    total++;
    if ({AD, CS, RD, WR, busy, done} !== 6'b111100 || bus !== 8'hFF || rdata !== 8'h00) begin
      bad++;
      $display("FAIL abort_now ctl=%b bus=%h rdata=%h exp 111100/ff/00",
               {AD, CS, RD, WR, busy, done}, bus, rdata);
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      if (done === 1'b1) nd++;
    end
    reset = 1'b1;
    idle_cycles(15, nd);
    total++;
    if (nd != 0 || rdata !== 8'h00) begin
      bad++;
      $display("FAIL abort_after done_pulses=%0d rdata=%h exp 0/00", nd, rdata);
    end
  endtask

  task automatic test_write();
    int nd, ni;
    run_txn(1'b0, 8'h21, 8'h09, 1'b0, nd);
    idle_cycles(2, ni);
    total++;
    if (nd != 1) begin
      bad++;
      $display("FAIL write_done_count got=%0d exp=1", nd);
    end
  endtask

  task automatic test_read();
    int nd, ni;
    run_txn(1'b1, 8'h22, 8'h00, 1'b0, nd);
    total++;
    if (rdata !== 8'h45) begin
      bad++;
      $display("FAIL read_22 rdata got=%h exp=45", rdata);
    end
    idle_cycles(2, ni);
    run_txn(1'b0, 8'h23, 8'h5C, 1'b0, nd);
    idle_cycles(2, ni);
    total++;
    if (rdata !== 8'h45) begin
      bad++;
      $display("FAIL read_hold_after_write rdata got=%h exp=45", rdata);
    end
  endtask

  task automatic test_back_to_back();
    int n1, n2, n3;
    run_txn(1'b0, 8'h2C, 8'h7E, 1'b1, n1);
    run_txn(1'b1, 8'h21, 8'h00, 1'b0, n2);
    idle_cycles(4, n3);
    total++;
    if (n1 + n2 + n3 != 2) begin
      bad++;
      $display("FAIL back_to_back done_pulses got=%0d exp=2", n1 + n2 + n3);
    end
  endtask

  task automatic test_random();
    int nd, ni, sum;
    logic r;
    sum = 0;
    for (int i = 0; i < 16; i++) begin
      r = 1'($urandom_range(0, 1));
      run_txn(r, 8'h20 + 8'($urandom_range(0, 15)), 8'($urandom_range(0, 254)), 1'b0, nd);
      sum += nd;
      if ($urandom_range(0, 1) == 1) idle_cycles($urandom_range(1, 3), ni);
    end
    idle_cycles(2, ni);
    total++;
    if (sum != 16) begin
      bad++;
      $display("FAIL random_done_count got=%0d exp=16", sum);
    end
  endtask

  task automatic test_irq();
    bit seen, stayed;
`ifdef IRQ_LATCH_EN
    IRQ = 1'b1; irq_ack = 1'b0;
    repeat (5) @(negedge clk);
    total++;
    if (irq_pending !== 1'b0) begin
      bad++;
      $display("FAIL irq_idle pending got=%b exp=0", irq_pending);
    end
    #2 IRQ = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (irq_pending === 1'b1) seen = 1'b1;
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL irq_set pending got=0 exp=1 within 3 cycles");
    end
    irq_ack = 1'b1;
    @(negedge clk);
    irq_ack = 1'b0;
    stayed = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (irq_pending !== 1'b0) stayed = 1'b0;
    end
    total++;
    if (!stayed) begin
      bad++;
      $display("FAIL irq_ack_held_low pending got=1 exp=0");
    end
    IRQ = 1'b1;
    repeat (5) @(negedge clk);
    irq_ack = 1'b1;
    #2 IRQ = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (irq_pending === 1'b1) seen = 1'b1;
    end
    irq_ack = 1'b0;
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL irq_set_wins pending got=0 exp=1");
    end
`else
    stayed = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      #2 IRQ = 1'($urandom_range(0, 1));
      irq_ack = 1'($urandom_range(0, 1));
      if (irq_pending !== 1'b0) stayed = 1'b0;
    end
    IRQ = 1'b1; irq_ack = 1'b0;
    total++;
    if (!stayed || seen) begin
      bad++;
      $display("FAIL irq_disabled pending got=1 exp=0");
    end
`endif
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i) + 8'h23;
    test_reset();
    test_abort();
    test_write();
    test_read();
    test_back_to_back();
    test_random();
    test_irq();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
